// File: rtl/fltr_result_serializer_pkg.sv
// fltr_result_serializer_pkg: shared widths, channel/state enums and the per-pixel bank record
package fltr_result_serializer_pkg;
    localparam int FLTR_NCHAN = 7;
    localparam int CHAN_W     = 3;
    localparam int DATA_W     = 16;
    localparam int COORD_W    = 9;

    typedef enum logic [CHAN_W-1:0] {F1, F2, F3, H1, H2, H3, H4} chan_e;
    typedef enum logic {IDLE, SEND} state_e;

    typedef struct packed {
        logic [FLTR_NCHAN-1:0][DATA_W-1:0] data;
        logic [COORD_W-1:0]                col;
        logic [COORD_W-1:0]                row;
    } bank_t;
endpackage

// File: rtl/fltr_strobe_delay.sv
// fltr_strobe_delay: aligns {new_data, frame_start} with the filter bank output latency
module fltr_strobe_delay #(
    parameter int FLTR_LATENCY = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);
    logic [FLTR_LATENCY-1:0][1:0] sr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sr_q <= '0;
        else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < FLTR_LATENCY; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[FLTR_LATENCY-1];
endmodule

// File: rtl/fltr_result_serializer.sv
// fltr_result_serializer: captures 7 filter results per pixel with position tags and
// streams them as 7 beats; a one-deep pending bank absorbs stalls, overflow drops the newest.
module fltr_result_serializer
    import fltr_result_serializer_pkg::*;
#(
    parameter int                 FLTR_LATENCY = 3,
    parameter logic [COORD_W-1:0] HORIZ_LEN    = 9'd316
) (
    input  logic               tm3_clk_v0,
    input  logic               reset,
    input  logic               vidin_new_data,
    input  logic               vidin_frame_start,
    input  logic [DATA_W-1:0]  vidin_f1,
    input  logic [DATA_W-1:0]  vidin_f2,
    input  logic [DATA_W-1:0]  vidin_f3,
    input  logic [DATA_W-1:0]  vidin_h1,
    input  logic [DATA_W-1:0]  vidin_h2,
    input  logic [DATA_W-1:0]  vidin_h3,
    input  logic [DATA_W-1:0]  vidin_h4,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHAN_W-1:0]  out_chan,
    output logic [COORD_W-1:0] out_col,
    output logic [COORD_W-1:0] out_row,
    output logic               out_last,
    output logic               overrun
);
    logic               cap_stb, cap_fs;
    state_e             state_q, state_d;
    chan_e              chan_q, chan_d;
    bank_t              pend_q, pend_d, act_q, act_d;
    logic               pend_full_q, pend_full_d, overrun_q, overrun_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d, tag_col, tag_row;
    logic               hs, last_hs, load_act, pend_free, take, wrap;

    fltr_strobe_delay #(.FLTR_LATENCY(FLTR_LATENCY)) u_dly (
        .clk_i (tm3_clk_v0),
        .rst_i (reset),
        .d_i   ({vidin_new_data, vidin_frame_start}),
        .q_o   ({cap_stb, cap_fs})
    );

    assign hs        = state_q == SEND && out_ready;
    assign last_hs   = hs && chan_q == H4;
    // Pending hands over on the same edge the active bank empties, so a capture there never drops
    assign load_act  = (state_q == IDLE || last_hs) && pend_full_q;
    assign pend_free = !pend_full_q || load_act;
    assign take      = cap_stb && pend_free;
    assign tag_col   = cap_fs ? '0 : col_q;
    assign tag_row   = cap_fs ? '0 : row_q;
    assign wrap      = tag_col == HORIZ_LEN - 1'b1;

    always_comb begin
        col_d       = cap_stb ? (wrap ? '0 : tag_col + 1'b1) : col_q;
        row_d       = cap_stb ? (wrap ? tag_row + 1'b1 : tag_row) : row_q;
        pend_full_d = take || (pend_full_q && !load_act);
        pend_d      = take ? {{vidin_h4, vidin_h3, vidin_h2, vidin_h1, vidin_f3, vidin_f2, vidin_f1},
                              tag_col, tag_row} : pend_q;
        act_d       = load_act ? pend_q : act_q;
        overrun_d   = overrun_q || (cap_stb && !pend_free);
        chan_d      = (load_act || last_hs) ? F1 : hs ? chan_e'(chan_q + 1'b1) : chan_q;
    end

    always_ff @(posedge tm3_clk_v0 or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            act_q       <= '0;
            overrun_q   <= 1'b0;
            chan_q      <= F1;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            overrun_q   <= overrun_d;
            chan_q      <= chan_d;
        end
    end

    always_ff @(posedge tm3_clk_v0 or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = load_act ? SEND : last_hs ? IDLE : state_q;
    end

    always_comb begin
        out_valid = state_q == SEND;
        out_last  = out_valid && chan_q == H4;
        out_data  = act_q.data[chan_q];
        out_chan  = chan_q;
        out_col   = act_q.col;
        out_row   = act_q.row;
        overrun   = overrun_q;
    end
endmodule

// File: tb/tb_fltr_result_serializer.sv
// tb_fltr_result_serializer: three instances (latency 3, 1, 5) on shared stimulus, each checked
// against a set-level scoreboard with a two-set occupancy limit.
module tb_fltr_result_serializer;
    localparam int NI = 3;

    logic        clk = 1'b0, rst = 1'b1, nd = 1'b0, fs = 1'b0, rdy = 1'b0;
    logic [15:0] fin [7];
    logic [15:0] od [NI];
    logic [2:0]  oc [NI];
    logic [8:0]  ocol [NI], orow [NI];
    logic        vo [NI], ol [NI], ovr [NI];

    logic [15:0] sbd [NI][32][7];
    logic [8:0]  sbc [NI][32], sbr [NI][32];
    int          hd [NI], tl [NI], beat [NI];
    logic [8:0]  mcol [NI], mrow [NI];
    logic        movr [NI];
    logic [1:0]  hist [8];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fltr_result_serializer #(.FLTR_LATENCY(g == 0 ? 3 : g == 1 ? 1 : 5)) dut (
            .tm3_clk_v0(clk), .reset(rst), .vidin_new_data(nd), .vidin_frame_start(fs),
            .vidin_f1(fin[0]), .vidin_f2(fin[1]), .vidin_f3(fin[2]), .vidin_h1(fin[3]),
            .vidin_h2(fin[4]), .vidin_h3(fin[5]), .vidin_h4(fin[6]),
            .out_data(od[g]), .out_valid(vo[g]), .out_ready(rdy), .out_chan(oc[g]),
            .out_col(ocol[g]), .out_row(orow[g]), .out_last(ol[g]), .overrun(ovr[g])
        );
    end

    function automatic int lat(input int k);
        return k == 0 ? 3 : k == 1 ? 1 : 5;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", tag, k, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < NI; k++) begin
            hd[k] = 0; tl[k] = 0; beat[k] = 0; mcol[k] = '0; mrow[k] = '0; movr[k] = 1'b0;
        end
        for (int i = 0; i < 8; i++) hist[i] = 2'b00;
    endtask

    task automatic rand_data();
        for (int c = 0; c < 7; c++) fin[c] = 16'($urandom);
    endtask

    // One clock: check current beats against the scoreboard, apply this edge's capture to the model
    task automatic step();
        int         slot;
        logic       last;
        logic [1:0] cs;
        logic [8:0] tc, tr;
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                last = 1'b0;
                if (vo[k]) begin
                    if (tl[k] == hd[k]) chk("spurious_valid", k, vo[k], 0);
                    else begin
                        slot = hd[k] % 32;
                        chk("data", k, od[k], sbd[k][slot][beat[k]]);
                        chk("chan", k, oc[k], beat[k]);
                        chk("col", k, ocol[k], sbc[k][slot]);
                        chk("row", k, orow[k], sbr[k][slot]);
                        chk("last", k, ol[k], beat[k] == 6);
                        if (rdy) begin
                            last = beat[k] == 6;
                            beat[k] = last ? 0 : beat[k] + 1;
                            if (last) hd[k]++;
                        end
                    end
                end
                cs = hist[lat(k)];
                if (cs[1]) begin
                    tc = cs[0] ? 9'd0 : mcol[k];
                    tr = cs[0] ? 9'd0 : mrow[k];
                    if (tl[k] - hd[k] < 2) begin
                        slot = tl[k] % 32;
                        for (int c = 0; c < 7; c++) sbd[k][slot][c] = fin[c];
                        sbc[k][slot] = tc;
                        sbr[k][slot] = tr;
                        tl[k]++;
                    end else movr[k] = 1'b1;
                    mcol[k] = tc == 9'd315 ? 9'd0 : tc + 9'd1;
                    mrow[k] = tc == 9'd315 ? tr + 9'd1 : tr;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 7; i > 1; i--) hist[i] = hist[i-1];
        hist[1] = rst ? 2'b00 : {nd, fs};
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                chk("rst_valid", k, vo[k], 0);
                chk("rst_overrun", k, ovr[k], 0);
                chk("rst_data", k, od[k], 0);
                chk("rst_chan", k, oc[k], 0);
                chk("rst_tags", k, {ocol[k], orow[k], ol[k]}, 0);
            end else chk("overrun", k, ovr[k], movr[k]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mreset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pixel(input logic f, input int gap, input logic rnd);
        nd = 1'b1; fs = f;
        if (rnd) rand_data();
        step();
        nd = 1'b0; fs = 1'b0;
        repeat (gap - 1) begin
            if (rnd) rand_data();
            step();
        end
    endtask

    initial begin
        int first [NI];
        int s;
        for (int c = 0; c < 7; c++) fin[c] = '0;
        mreset();
        step();
        do_reset();

        // frame start pixel with constant 1..7 data; first beat latency per instance
        rdy = 1'b1;
        for (int c = 0; c < 7; c++) fin[c] = 16'(c + 1);
        for (int k = 0; k < NI; k++) first[k] = -1;
        nd = 1'b1; fs = 1'b1;
        for (int st = 1; st <= 16; st++) begin
            step();
            nd = 1'b0; fs = 1'b0;
            for (int k = 0; k < NI; k++) if (vo[k] && first[k] < 0) first[k] = st;
        end
        for (int k = 0; k < NI; k++) chk("latency", k, first[k], lat(k) + 2);
        repeat (8) step();

        // full line plus one: column wrap and row increment
        for (int p = 0; p < 317; p++) pixel(p == 0, 8, 1'b1);
        repeat (16) step();

        // consumer stall: held set, pending set, dropped set
        rdy = 1'b0;
        for (int p = 0; p < 3; p++) pixel(1'b0, 8, 1'b1);
        chk("stall_overrun", 0, ovr[0], 1);
        rdy = 1'b1;
        repeat (30) step();

        // capture on the exact edge of the chan-6 handshake with pending full
        do_reset();
        rdy = 1'b0;
        pixel(1'b1, 8, 1'b1);
        pixel(1'b0, 8, 1'b1);
        rdy = 1'b1;
        repeat (3) step();
        pixel(1'b0, 24, 1'b1);
        chk("samecyc_overrun", 0, ovr[0], 0);

        // reset mid-send at chan 3, then tags restart at (0,0)
        nd = 1'b1; rand_data();
        step();
        nd = 1'b0;
        s = 0;
        while (!(vo[0] && oc[0] == 3) && s < 20) begin step(); s++; end
        chk("reach_chan3", 0, s < 20, 1);
        do_reset();
        pixel(1'b0, 20, 1'b1);

        // randomized traffic with stalls and occasional frame starts
        for (int i = 0; i < 3000; i++) begin
            nd = $urandom_range(0, 7) == 0;
            fs = nd && $urandom_range(0, 31) == 0;
            rdy = $urandom_range(0, 4) != 0;
            rand_data();
            step();
        end
        nd = 1'b0; fs = 1'b0; rdy = 1'b1;
        repeat (40) step();
        for (int k = 0; k < NI; k++) chk("drain", k, tl[k] - hd[k], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
